fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC register and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instruction words in a small FIFO and presents {pc, instruction, opcode} to decode over a valid/ready handshake.
- Handles redirects (branch/JAL/JALR targets) by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_stage_if.sv | 49 ++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - bus bundle between the fetch stage, instruction memory, execute and decode
//
// Purpose: groups every handshake/data signal of fetch_stage so the stage
// and its environment connect through one port each.
// Signal summary:
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_rsp_valid/data         in-order response words from memory
//   redirect_valid/pc           control-flow redirect from execute
//   inst_valid/ready            instruction handshake to decode
//   inst_word/inst_pc/op        head-of-buffer instruction, its PC, opcode
//   misalign_err                sticky misaligned-redirect flag
// Modports: master = fetch stage side, slave = environment side.

interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_word;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [6:0]            op;
  logic                  misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_word, inst_pc, op, misalign_err,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_word, inst_pc, op, misalign_err,
    output inst_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, credit-limited requests and output buffer
//
// Purpose: owns the PC, issues word-aligned fetches, buffers returned words
// with their PCs and hands {pc, word, opcode} to decode. Redirects flush the
// buffer and discard responses still in flight for the old path.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (memory request/response, redirect,
//          decode handshake, misalign_err)

module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_drop;
  logic [CW-1:0]         r_count;
  logic                  r_misalign;
  logic [PW-1:0]         r_buf_rd;
  logic [PW-1:0]         r_buf_wr;
  logic [PW-1:0]         r_tag_rd;
  logic [PW-1:0]         r_tag_wr;
  logic [DATA_WIDTH-1:0] r_buf_data [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_tag      [BUF_DEPTH];

  logic [CW:0] w_occupancy;
  logic        w_credit;
  logic        w_req_fire;
  logic        w_pop;
  logic        w_push;
  logic        w_empty;
  logic        w_dropping;

  // Requests in flight plus words already buffered may never exceed the
  // buffer size, so every response that is kept has a free slot.
  assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_credit    = w_occupancy < (CW+1)'(BUF_DEPTH);

  // rst_n gates the request so it is low throughout reset and can rise in
  // the first cycle after release.
  assign bus.imem_req_valid = rst_n & (r_state == RUN) & w_credit & ~bus.redirect_valid;
  assign bus.imem_req_addr  = r_pc;
  assign w_req_fire         = bus.imem_req_valid & bus.imem_req_ready;

  assign w_empty        = (r_count == '0);
  assign bus.inst_valid = ~w_empty;
  assign w_pop          = bus.inst_valid & bus.inst_ready;
  assign w_dropping     = (r_drop != '0);
  assign w_push         = bus.imem_rsp_valid & ~w_dropping & ~bus.redirect_valid;

  assign bus.inst_word    = w_empty ? '0 : r_buf_data[r_buf_rd];
  assign bus.inst_pc      = w_empty ? '0 : r_buf_pc[r_buf_rd];
  assign bus.op           = bus.inst_word[6:0];
  assign bus.misalign_err = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
    end else if (bus.redirect_valid) begin
      // Every request still outstanding after this cycle belongs to the old
      // path; a response arriving right now is discarded as well.
      r_pc       <= bus.redirect_pc;
      r_inflight <= r_inflight - CW'(bus.imem_rsp_valid);
      r_drop     <= r_inflight - CW'(bus.imem_rsp_valid);
      r_count    <= '0;
      r_buf_rd   <= '0;
      r_buf_wr   <= '0;
      r_tag_rd   <= '0;
      r_tag_wr   <= '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        r_state    <= HALT;
        r_misalign <= 1'b1;
      end else begin
        r_state    <= RUN;
        r_misalign <= 1'b0;
      end
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + ADDR_WIDTH'(4);
        r_tag_wr <= r_tag_wr + PW'(1);
      end
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && w_dropping) begin
        r_drop <= r_drop - CW'(1);
      end
      // Dropped responses never had a tag (the tag queue was flushed with
      // the redirect), so only kept responses advance the tag read pointer.
      if (w_push) begin
        r_buf_wr <= r_buf_wr + PW'(1);
        r_tag_rd <= r_tag_rd + PW'(1);
      end
      if (w_pop) begin
        r_buf_rd <= r_buf_rd + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tag[r_tag_wr] <= r_pc;
    end
    if (w_push) begin
      r_buf_data[r_buf_wr] <= bus.imem_rsp_data;
      r_buf_pc[r_buf_wr]   <= r_tag[r_tag_rd];
    end
  end

  always @(posedge clk) begin
    if (rst_n && w_push) begin
      assert (r_count != CW'(BUF_DEPTH) || w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a randomized memory model
//
// Purpose: drives fetch_stage through its interface with a latency-randomized
// in-order memory, random decode backpressure and redirects, and checks the
// request address stream and the instruction stream against the program-order
// sequence expected after each reset or redirect.

module tb_fetch_stage;
  localparam int             AW        = 32;
  localparam int             DW        = 32;
  localparam int             BD        = 2;
  localparam logic [AW-1:0]  RPC       = 32'h0000_0000;
  localparam int             EPOCH_LEN = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic [AW-1:0] addr; int due; } pend_t;
  pend_t         pend_q[$];
  logic [AW-1:0] exp_req_q[$];
  logic [AW-1:0] exp_inst_q[$];
  logic [AW-1:0] mon_pc;
  bit            exp_halt;
  bit            exp_err;
  int passed = 0, total = 0, cyc = 0, pops = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100, ir_pct = 100;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic missing(input string name, input string what);
    total++;
    $display("FAIL %s: got %s required none", name, what);
  endtask

  // After reset or a redirect to t, the fetch path must produce t, t+4, ...
  // in program order; a misaligned target produces nothing until the next
  // aligned redirect.
  task automatic start_epoch(input logic [AW-1:0] t);
    exp_req_q.delete();
    exp_inst_q.delete();
    if (t[1:0] == 2'b00) begin
      for (int k = 0; k < EPOCH_LEN; k++) begin
        exp_req_q.push_back(t + AW'(4 * k));
        exp_inst_q.push_back(t + AW'(4 * k));
      end
      exp_halt = 1'b0;
      exp_err  = 1'b0;
    end else begin
      exp_halt = 1'b1;
      exp_err  = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs just after posedge, record accepted
  // requests at negedge, advance past the next posedge.
  task automatic tick(input bit redir, input logic [AW-1:0] tgt);
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    bus.inst_ready     = (int'($urandom_range(0, 99)) < ir_pct);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready)
      pend_q.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    @(posedge clk);
    cyc++;
    #1;
    if (redir) start_epoch(tgt);
  endtask

  // Monitor: compares whatever the DUT presents against the expected queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("misalign_err", bus.misalign_err, exp_err);
        if (bus.redirect_valid) begin
          check("req_during_redirect", bus.imem_req_valid, 1'b0);
        end else begin
          if (exp_halt) check("req_while_halted", bus.imem_req_valid, 1'b0);
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (exp_req_q.size() == 0) missing("req_unexpected", "request");
            else check("req_addr", bus.imem_req_addr, exp_req_q.pop_front());
          end
          if (bus.inst_valid && bus.inst_ready) begin
            pops++;
            if (exp_inst_q.size() == 0) missing("inst_unexpected", "instruction");
            else begin
              mon_pc = exp_inst_q.pop_front();
              check("inst_pc", bus.inst_pc, mon_pc);
              check("inst_word", bus.inst_word, mem_word(mon_pc));
              check("op", bus.op, {57'd0, mem_word(mon_pc) >> 0} & 64'h7F);
            end
          end
          if (!bus.inst_valid) check("empty_word", bus.inst_word, '0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] t;
    int            since;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;

    #12;
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_misalign", bus.misalign_err, 1'b0);
    check("rst_inst_word", bus.inst_word, '0);
    check("rst_inst_pc", bus.inst_pc, '0);
    check("rst_op", bus.op, '0);

    start_epoch(RPC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency 1, always ready, decode always ready.
    repeat (20) tick(1'b0, '0);

    // Decode backpressure for 10 cycles.
    ir_pct = 0;
    repeat (10) tick(1'b0, '0);
    check("bp_req_valid", bus.imem_req_valid, 1'b0);
    check("bp_inst_valid", bus.inst_valid, 1'b1);
    ir_pct = 100;
    repeat (10) tick(1'b0, '0);

    // Redirect with latency 3 and requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (6) tick(1'b0, '0);
    tick(1'b1, 32'h0000_0100);
    repeat (20) tick(1'b0, '0);

    // Randomized traffic with redirects (aligned, misaligned, near wrap).
    lat_min = 1; lat_max = 4; rdy_pct = 70; ir_pct = 70;
    since = 0;
    for (int i = 0; i < 500; i++) begin
      if (since >= 100 || $urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 9))
          0:       t = {30'($urandom), 2'($urandom_range(1, 3))};
          1:       t = 32'hFFFF_FFF8;
          default: t = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        endcase
        tick(1'b1, t);
        since = 0;
      end else begin
        tick(1'b0, '0);
        since++;
      end
    end
    tick(1'b1, 32'h0000_0040);
    repeat (10) tick(1'b0, '0);

    // Misaligned redirect halts fetch until an aligned redirect.
    rdy_pct = 100; ir_pct = 100;
    tick(1'b1, 32'h0000_0102);
    repeat (20) tick(1'b0, '0);
    check("halt_err", bus.misalign_err, 1'b1);
    check("halt_req_valid", bus.imem_req_valid, 1'b0);
    tick(1'b1, 32'h0000_0200);
    for (int i = 0; i < 30 && exp_req_q.size() == EPOCH_LEN; i++) tick(1'b0, '0);
    check("resume_after_halt", exp_req_q.size() < EPOCH_LEN, 1'b1);
    check("resume_err", bus.misalign_err, 1'b0);
    repeat (10) tick(1'b0, '0);

    // Asynchronous reset between clock edges with requests outstanding.
    lat_min = 2; lat_max = 2;
    repeat (8) tick(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_valid", bus.imem_req_valid, 1'b0);
    check("async_inst_valid", bus.inst_valid, 1'b0);
    check("async_inst_word", bus.inst_word, '0);
    check("async_misalign", bus.misalign_err, 1'b0);
    pend_q.delete();
    bus.imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) tick(1'b0, '0);
    start_epoch(RPC);
    rst_n = 1'b1;
    repeat (30) tick(1'b0, '0);

    check("progress", pops >= 100, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
